// File: rtl/lsu_master_pkg.sv
// lsu_master shared constants: FSM state encodings and access size codes.
// Imported by lsu_master and lsu_align.
package lsu_master_pkg;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for lsu_master: strobes, replicated store data,
// extended load value and alignment check. Purely combinational.
module lsu_align
  import lsu_master_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misaligned_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  assign byte_sh = mem_rdata_i >> {addr_i, 3'b000};
  assign half_sh = mem_rdata_i >> {addr_i[1], 4'b0000};

  always_comb begin
    wstrb_o      = 4'b0000;
    wdata_o      = store_data_i;
    load_o       = mem_rdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_B: begin
        wstrb_o = 4'b0001 << addr_i;
        wdata_o = {4{store_data_i[7:0]}};
        load_o  = {{24{sgn_i & byte_sh[7]}},
                   byte_sh[7:0]};
      end
      SZ_H: begin
        wstrb_o      = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o      = {2{store_data_i[15:0]}};
        load_o       = {{16{sgn_i & half_sh[15]}},
                        half_sh[15:0]};
        misaligned_o = addr_i[0];
      end
      SZ_W: begin
        wstrb_o      = 4'b1111;
        misaligned_o = |addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator: decodes one op per start, drives a req/ready
// memory handshake, returns extended load data with a done pulse.
module lsu_master
  import lsu_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_lb,
  input  logic        is_lbu,
  input  logic        is_lh,
  input  logic        is_lhu,
  input  logic        is_lw,
  input  logic        is_sb,
  input  logic        is_sh,
  input  logic        is_sw,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ld_q, ld_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;

  logic        dec_ok, dec_st, dec_sgn;
  logic [1:0]  dec_size;

  always_comb begin
    dec_ok   = 1'b1;
    dec_st   = 1'b0;
    dec_sgn  = 1'b0;
    dec_size = SZ_W;
    priority case (1'b1)
      is_lw:  dec_size = SZ_W;
      is_lh:  begin dec_size = SZ_H; dec_sgn = 1'b1; end
      is_lhu: dec_size = SZ_H;
      is_lb:  begin dec_size = SZ_B; dec_sgn = 1'b1; end
      is_lbu: dec_size = SZ_B;
      is_sw:  begin dec_size = SZ_W; dec_st = 1'b1; end
      is_sh:  begin dec_size = SZ_H; dec_st = 1'b1; end
      is_sb:  begin dec_size = SZ_B; dec_st = 1'b1; end
      default: dec_ok = 1'b0;
    endcase
  end

  // One aligner serves both phases: fresh decode in IDLE,
  // latched op fields while extracting read data in REQ.
  logic        idle;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;
  logic        al_mis;

  assign idle = state_q == LSU_IDLE;

  lsu_align u_align (
    .size_i       (idle ? dec_size : size_q),
    .sgn_i        (idle ? dec_sgn : sgn_q),
    .addr_i       (idle ? address[1:0] : off_q),
    .store_data_i (store_data),
    .mem_rdata_i  (mem_rdata),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .load_o       (al_load),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    ld_d    = ld_q;
    mis_d   = mis_q;
    to_d    = to_q;
    case (state_q)
      LSU_IDLE: begin
        if (start && dec_ok) begin
          mis_d = al_mis;
          to_d  = 1'b0;
          cnt_d = '0;
          if (al_mis) begin
            state_d = LSU_DONE;
          end else begin
            state_d = LSU_REQ;
            addr_d  = {address[31:2], 2'b00};
            we_d    = dec_st;
            wstrb_d = dec_st ? al_wstrb : 4'b0000;
            wdata_d = al_wdata;
            size_d  = dec_size;
            sgn_d   = dec_sgn;
            off_d   = address[1:0];
          end
        end
      end
      LSU_REQ: begin
        // Handshake takes precedence over an expiring timeout.
        if (mem_ready) begin
          if (!we_q) ld_d = al_load;
          state_d = LSU_DONE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      size_q  <= SZ_B;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  assign mem_req    = state_q == LSU_REQ;
  assign done       = state_q == LSU_DONE;
  assign busy       = mem_req | done;
  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_wdata  = wdata_q;
  assign load_data  = ld_q;
  assign misaligned = mis_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: vector table plus sequences for
// wait states, timeout, busy-time start and async reset.
module tb_lsu_master;

  localparam logic [7:0] F_LW  = 8'h80;
  localparam logic [7:0] F_LH  = 8'h40;
  localparam logic [7:0] F_LHU = 8'h20;
  localparam logic [7:0] F_LB  = 8'h10;
  localparam logic [7:0] F_LBU = 8'h08;
  localparam logic [7:0] F_SW  = 8'h04;
  localparam logic [7:0] F_SH  = 8'h02;
  localparam logic [7:0] F_SB  = 8'h01;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [7:0]  flags = 0;
  logic [31:0] address = 0;
  logic [31:0] store_data = 0;
  logic        mem_ready = 0;
  logic [31:0] mem_rdata = 0;
  logic        busy, done, misaligned, timeout;
  logic        mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_master #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .is_lb(flags[4]), .is_lbu(flags[3]),
    .is_lh(flags[6]), .is_lhu(flags[5]),
    .is_lw(flags[7]), .is_sb(flags[0]),
    .is_sh(flags[1]), .is_sw(flags[2]),
    .address(address), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data),
    .misaligned(misaligned), .timeout(timeout),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [7:0]  f;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
    logic        e_mis;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [7:0] f,
                        input logic [31:0] a,
                        input logic [31:0] sd);
    @(negedge clk);
    flags = f; address = a; store_data = sd; start = 1;
    @(posedge clk); #1;
    start = 0; flags = 0;
  endtask

  // Runs the REQ phase; ready rises after dly stall cycles.
  // Checks request fields every REQ cycle. Returns REQ cycles.
  task automatic serve(input int dly, input logic [31:0] rd,
                       input logic [31:0] ea, input logic ew,
                       input logic [3:0] es, input logic [31:0] ewd,
                       input bit poke, output int n);
    n = 0;
    while (!done && n < 40) begin
      chk("req_hi", {31'd0, mem_req}, 32'd1);
      chk("busy_req", {31'd0, busy}, 32'd1);
      chk("addr", mem_addr, ea);
      chk("we", {31'd0, mem_we}, {31'd0, ew});
      chk("wstrb", {28'd0, mem_wstrb}, {28'd0, es});
      if (ew) chk("wdata", mem_wdata, ewd);
      if (n >= dly) begin mem_ready = 1; mem_rdata = rd; end
      if (poke && n == 1) begin
        start = 1; flags = F_SB; address = 32'h0000_0FF1;
      end
      @(posedge clk); #1;
      mem_ready = 0; mem_rdata = 32'h5555_AAAA;
      start = 0; flags = 0;
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic after_done();
    chk("req_in_done", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  int n;
  logic [31:0] ld_prev;

  initial begin
    vt[0]  = '{F_SB, 32'h103, 32'hA5, 0, 32'h100, 1, 4'b1000,
               32'hA5A5A5A5, 32'h0, 0};
    vt[1]  = '{F_LB, 32'h102, 0, 32'h00F00000, 32'h100, 0, 0,
               0, 32'hFFFFFFF0, 0};
    vt[2]  = '{F_LBU, 32'h102, 0, 32'h00F00000, 32'h100, 0, 0,
               0, 32'h000000F0, 0};
    vt[3]  = '{F_LHU, 32'h102, 0, 32'h00F00000, 32'h100, 0, 0,
               0, 32'h000000F0, 0};
    vt[4]  = '{F_LH, 32'h100, 0, 32'h00008001, 32'h100, 0, 0,
               0, 32'hFFFF8001, 0};
    vt[5]  = '{F_LW, 32'h202, 0, 0, 0, 0, 0, 0, 32'hFFFF8001, 1};
    vt[6]  = '{F_SH, 32'h201, 32'h1, 0, 0, 0, 0, 0,
               32'hFFFF8001, 1};
    vt[7]  = '{F_SH, 32'h202, 32'h1234BEEF, 0, 32'h200, 1,
               4'b1100, 32'hBEEFBEEF, 32'hFFFF8001, 0};
    vt[8]  = '{F_LW, 32'h204, 0, 32'hDEADBEEF, 32'h204, 0, 0,
               0, 32'hDEADBEEF, 0};
    vt[9]  = '{F_LW | F_LB | F_SW, 32'h010, 0, 32'h11223344,
               32'h010, 0, 0, 0, 32'h11223344, 0};
    vt[10] = '{F_LB | F_SB, 32'h001, 0, 32'h00008000, 32'h000,
               0, 0, 0, 32'hFFFFFF80, 0};
    vt[11] = '{F_SH | F_SB, 32'h006, 32'hCAFE, 0, 32'h004, 1,
               4'b1100, 32'hCAFECAFE, 32'hFFFFFF80, 0};
    vt[12] = '{F_LHU | F_LBU, 32'h002, 0, 32'h80010000, 32'h000,
               0, 0, 0, 32'h00008001, 0};
    vt[13] = '{F_SB, 32'h100, 32'h5A, 0, 32'h100, 1, 4'b0001,
               32'h5A5A5A5A, 32'h00008001, 0};

    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      launch(vt[i].f, vt[i].a, vt[i].sd);
      if (vt[i].e_mis) begin
        chk("mis_done", {31'd0, done}, 32'd1);
      end else begin
        serve(0, vt[i].rd, vt[i].e_addr, vt[i].e_we,
              vt[i].e_strb, vt[i].e_wdata, 0, n);
        chk("latency", n, 1);
      end
      chk("misaligned", {31'd0, misaligned},
          {31'd0, vt[i].e_mis});
      chk("timeout0", {31'd0, timeout}, 32'd0);
      chk("load_data", load_data, vt[i].e_ld);
      after_done();
    end

    // Stalled store; start pulsed while busy and while in DONE.
    launch(F_SW, 32'h400, 32'h0BADF00D);
    serve(3, 0, 32'h400, 1, 4'b1111, 32'h0BADF00D, 1, n);
    chk("sw_cycles", n, 4);
    chk("sw_to", {31'd0, timeout}, 32'd0);
    start = 1; flags = F_SB; address = 32'h10;
    @(posedge clk); #1;
    start = 0; flags = 0;
    chk("done_start_ign", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("still_idle", {31'd0, busy}, 32'd0);

    // Timeout with ready never asserted.
    ld_prev = load_data;
    launch(F_LW, 32'h300, 0);
    serve(100, 32'hFFFFFFFF, 32'h300, 0, 0, 0, 0, n);
    chk("to_cycles", n, 4);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    chk("to_ld_keep", load_data, ld_prev);
    after_done();

    // Start with no flag set.
    launch(8'h00, 32'h0, 0);
    chk("noflag_busy", {31'd0, busy}, 32'd0);
    chk("noflag_done", {31'd0, done}, 32'd0);

    // Async reset in the middle of REQ.
    launch(F_SW, 32'h500, 32'h12345678);
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ld", load_data, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_wdata", mem_wdata, 32'd0);
    chk("arst_strb", {28'd0, mem_wstrb}, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1;

    launch(F_LHU, 32'h602, 0);
    serve(1, 32'hBEEF0000, 32'h600, 0, 0, 0, 0, n);
    chk("post_rst_n", n, 2);
    chk("post_rst_ld", load_data, 32'h0000BEEF);
    after_done();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
